// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the dma_copy engine.
//   state_t    - engine state encoding (IDLE, READ, WRITE, DONE)
//   WORD_BYTES - address stride per transferred word
//   FULL_MASK  - byte write enables for a full-word write
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] FULL_MASK  = 4'b1111;

endpackage

// File: rtl/dma_copy.sv
// dma_copy: word-granular memory-to-memory copy engine, bus initiator.
//
// Optional feature macro: DMA_FILL_EN (adds fill_in / fill_value_in; with
// fill_in=1 at start, fill_value is written to consecutive dst words and no
// reads are issued).
//
// Ports:
//   clk, reset_n           clock, async active-low reset
//   start_in               begin transfer (sampled only in IDLE)
//   src_in, dst_in         byte addresses, bits [1:0] ignored
//   len_in                 word count; 0 completes with no bus traffic
//   busy_out, done_out     in-progress flag, one-cycle completion pulse
//   address_out, sel_out   bus address (word aligned) and request
//   write_mask_out         0 on reads, 4'b1111 on writes
//   write_value_out        write data (copy buffer)
//   read_value_in          read data, valid with sel_out && ready_in
//   ready_in               beat accept
//   fill_in, fill_value_in (DMA_FILL_EN only) fill mode select and pattern
//
// state | meaning
// IDLE  | waiting for start_in
// READ  | read beat at src pending
// WRITE | write beat at dst pending
// DONE  | one-cycle completion pulse
module dma_copy
  import dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_in,
  input  logic [31:0]          src_in,
  input  logic [31:0]          dst_in,
  input  logic [LEN_WIDTH-1:0] len_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [31:0]          address_out,
  output logic                 sel_out,
  output logic [3:0]           write_mask_out,
  output logic [31:0]          write_value_out,
  input  logic [31:0]          read_value_in,
  input  logic                 ready_in
`ifdef DMA_FILL_EN
  ,
  input  logic                 fill_in,
  input  logic [31:0]          fill_value_in
`endif
);

  state_t               state_q, state_d;
  logic [31:0]          src_q, dst_q, buf_q;
  logic [LEN_WIDTH-1:0] count_q;
  logic                 fill_q;
  logic                 fill_start;

`ifdef DMA_FILL_EN
  assign fill_start = fill_in;
`else
  assign fill_start = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Bus outputs decode from registered state and address regs only, so they
  // stay frozen during stalls and never see ready_in combinationally.
  always_comb begin
    state_d        = state_q;
    sel_out        = 1'b0;
    address_out    = 32'h0;
    write_mask_out = 4'h0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          if (len_in == '0)    state_d = DONE;
          else if (fill_start) state_d = WRITE;
          else                 state_d = READ;
        end
      end
      READ: begin
        sel_out     = 1'b1;
        address_out = src_q;
        if (ready_in) state_d = WRITE;
      end
      WRITE: begin
        sel_out        = 1'b1;
        address_out    = dst_q;
        write_mask_out = FULL_MASK;
        if (ready_in) begin
          if (count_q == LEN_WIDTH'(1)) state_d = DONE;
          else if (fill_q)              state_d = WRITE;
          else                          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_out        = (state_q != IDLE);
  assign done_out        = (state_q == DONE);
  assign write_value_out = buf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q   <= 32'h0;
      dst_q   <= 32'h0;
      buf_q   <= 32'h0;
      count_q <= '0;
      fill_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            src_q   <= src_in & ~32'h3;
            dst_q   <= dst_in & ~32'h3;
            count_q <= len_in;
            fill_q  <= fill_start;
`ifdef DMA_FILL_EN
            // In fill mode the copy buffer doubles as the pattern register.
            if (fill_in) buf_q <= fill_value_in;
`endif
          end
        end
        READ: begin
          if (ready_in) begin
            buf_q <= read_value_in;
            src_q <= src_q + 32'(WORD_BYTES);
          end
        end
        WRITE: begin
          if (ready_in) begin
            dst_q   <= dst_q + 32'(WORD_BYTES);
            count_q <= count_q - LEN_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: self-checking bench for dma_copy. A memory model answers bus
// beats with random stalls; expected beat sequences and completion times are
// derived from the transfer parameters alone.
module tb_dma_copy;

  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_in;
  logic [31:0]   src_in, dst_in;
  logic [LW-1:0] len_in;
  logic          busy_out, done_out, sel_out;
  logic [31:0]   address_out, write_value_out, read_value_in;
  logic [3:0]    write_mask_out;
  logic          ready_in;
  logic          fill_in;
  logic [31:0]   fill_value_in;

  always #5 clk = ~clk;

  dma_copy #(.LEN_WIDTH(LW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_in       (start_in),
    .src_in         (src_in),
    .dst_in         (dst_in),
    .len_in         (len_in),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .address_out    (address_out),
    .sel_out        (sel_out),
    .write_mask_out (write_mask_out),
    .write_value_out(write_value_out),
    .read_value_in  (read_value_in),
    .ready_in       (ready_in)
`ifdef DMA_FILL_EN
    ,
    .fill_in        (fill_in),
    .fill_value_in  (fill_value_in)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } beat_t;

  beat_t got_q[$];
  beat_t exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          stall_pct;
    int          exp_done;   // done cycle after start with no stalls
    logic        fill;
    logic [31:0] fval;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int          stalls = 0;
    int          sel_cycles = 0;
    int          done_k = -1;
    logic        prev_stall = 1'b0;
    logic [31:0] p_addr = 0, p_wv = 0;
    logic [3:0]  p_mask = 0;
    logic [31:0] s = v.src & ~32'h3;
    logic [31:0] d = v.dst & ~32'h3;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < v.len; i++) begin
      logic [31:0] sa = s + 32'(4 * i);
      logic [31:0] da = d + 32'(4 * i);
      if (!v.fill) exp_q.push_back('{sa, 4'h0, 32'h0});
      exp_q.push_back('{da, 4'hF, v.fill ? v.fval : rd(sa)});
    end

    @(negedge clk);
    start_in = 1'b1; src_in = v.src; dst_in = v.dst; len_in = LW'(v.len);
    fill_in = v.fill; fill_value_in = v.fval;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 400; k++) begin
      if (prev_stall) begin
        chk({v.name, "_stall_sel"},  {31'h0, sel_out}, 32'h1);
        chk({v.name, "_stall_addr"}, address_out, p_addr);
        chk({v.name, "_stall_mask"}, {28'h0, write_mask_out}, {28'h0, p_mask});
        chk({v.name, "_stall_wv"},   write_value_out, p_wv);
      end
      if (done_out) begin
        done_k = k;
        chk({v.name, "_done_sel"}, {31'h0, sel_out}, 32'h0);
        break;
      end
      chk({v.name, "_busy"}, {31'h0, busy_out}, 32'h1);
      start_in = 1'($urandom_range(1));   // must be ignored while busy
      if (sel_out) begin
        sel_cycles++;
        ready_in = (32'($urandom_range(99)) >= 32'(v.stall_pct));
        read_value_in = (ready_in && write_mask_out == 4'h0) ? rd(address_out) : $urandom();
        if (ready_in) begin
          got_q.push_back('{address_out, write_mask_out,
                            (write_mask_out == 4'h0) ? 32'h0 : write_value_out});
          if (write_mask_out != 4'h0) mem[address_out] = write_value_out;
        end else begin
          stalls++;
        end
        prev_stall = !ready_in;
        p_addr = address_out; p_mask = write_mask_out; p_wv = write_value_out;
      end else begin
        ready_in = 1'b0;
        prev_stall = 1'b0;
      end
      @(negedge clk);
    end
    ready_in = 1'b0;
    start_in = 1'b1;                       // asserted in DONE: must be ignored
    chk({v.name, "_done_cycle"}, 32'(done_k), 32'(v.exp_done + stalls));
    @(negedge clk);
    start_in = 1'b0;
    chk({v.name, "_busy_after"}, {31'h0, busy_out}, 32'h0);
    chk({v.name, "_done_after"}, {31'h0, done_out}, 32'h0);
    chk({v.name, "_sel_cycles"}, 32'(sel_cycles),
        32'((v.fill ? v.len : 2 * v.len) + stalls));
    chk({v.name, "_nbeats"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_b%0d_addr", v.name, i), got_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s_b%0d_mask", v.name, i), {28'h0, got_q[i].mask}, {28'h0, exp_q[i].mask});
      chk($sformatf("%s_b%0d_data", v.name, i), got_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    reset_n = 1'b0; start_in = 1'b0; src_in = 0; dst_in = 0; len_in = 0;
    ready_in = 1'b0; read_value_in = 0; fill_in = 1'b0; fill_value_in = 0;

    mem[32'h100] = 32'h1111_1111;
    mem[32'h104] = 32'h2222_2222;
    mem[32'h108] = 32'h3333_3333;

    vecs.push_back('{"copy3",   32'h100,      32'h200,  3, 0,  7, 1'b0, 32'h0});
    vecs.push_back('{"len0",    32'h300,      32'h400,  0, 0,  1, 1'b0, 32'h0});
    vecs.push_back('{"wrap",    32'hFFFF_FFFC, 32'h800, 2, 0,  5, 1'b0, 32'h0});
    vecs.push_back('{"stall4",  32'h1000,     32'h2000, 4, 40, 9, 1'b0, 32'h0});
    vecs.push_back('{"unalign", 32'h3003,     32'h4002, 1, 0,  3, 1'b0, 32'h0});
`ifdef DMA_FILL_EN
    vecs.push_back('{"fill2",   32'h0,        32'h40,   2, 0,  3, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{"fillst",  32'h0,        32'h80,   3, 50, 4, 1'b1, 32'h0BAD_F00D});
`endif

    #12;
    chk("rst_busy", {31'h0, busy_out}, 32'h0);
    chk("rst_done", {31'h0, done_out}, 32'h0);
    chk("rst_sel",  {31'h0, sel_out},  32'h0);
    chk("rst_addr", address_out, 32'h0);
    chk("rst_mask", {28'h0, write_mask_out}, 32'h0);
    chk("rst_wv",   write_value_out, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_xfer(vecs[i]);

    // Reset asserted while a write beat is pending.
    @(negedge clk);
    start_in = 1'b1; src_in = 32'h500; dst_in = 32'h600; len_in = LW'(5); fill_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_in = 1'b0; ready_in = 1'b1; read_value_in = rd(address_out);
    @(negedge clk);
    chk("rstmid_pre_mask", {28'h0, write_mask_out}, 32'hF);
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid_sel",  {31'h0, sel_out},  32'h0);
    chk("rstmid_busy", {31'h0, busy_out}, 32'h0);
    chk("rstmid_addr", address_out, 32'h0);
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_nodone", {31'h0, done_out}, 32'h0);
    end
    reset_n = 1'b1;
    run_xfer(vecs[0]);

    for (int r = 0; r < 10; r++) begin
      vec_t v;
      int   l = int'($urandom_range(6, 1));
      v.name = $sformatf("rnd%0d", r);
      v.src = $urandom();
      v.dst = v.src + 32'h0001_0000;
      v.len = l;
      v.stall_pct = int'($urandom_range(50));
      v.exp_done = 1 + 2 * l;
      v.fill = 1'b0;
      v.fval = 32'h0;
      run_xfer(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
